// File: rtl/floppy_track_buffer_if.sv
// floppy_track_buffer_if: host (IWM) port, drive control/status and SD sector DMA signals
// for one floppy_track_buffer; master drives the buffer, slave is the buffer itself.
interface floppy_track_buffer_if;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic        ram_we;
    logic [5:0]  track;
    logic        busy;
    logic        change;
    logic        mount;
    logic        ready;
    logic        active;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output ram_addr, ram_di, ram_we, track, change, mount,
        output sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_ack,
        input  ram_do, busy, ready, active, sd_buff_din, sd_lba, sd_rd, sd_wr
    );
    modport slave (
        input  ram_addr, ram_di, ram_we, track, change, mount,
        input  sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_ack,
        output ram_do, busy, ready, active, sd_buff_din, sd_lba, sd_rd, sd_wr
    );
endinterface

// File: rtl/floppy_track_buffer.sv
// floppy_track_buffer: one-track (13 x 512 B) nibble buffer between the IWM and SD sector DMA.
// Define FLOPPY_WRITEBACK_EN to write a dirty track back to the image before switching tracks.
module floppy_track_buffer #(
    parameter int SECTORS_PER_TRACK = 13,
    parameter int ADDR_W = 13
) (
    input logic clk_sys,
    input logic reset,
    floppy_track_buffer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_XFER
`ifdef FLOPPY_WRITEBACK_EN
        , WR_REQ, WR_XFER
`endif
    } state_t;
    localparam logic [3:0] LAST_SEC = 4'(SECTORS_PER_TRACK - 1);

    state_t     state_q, state_d;
    logic [5:0] cur_track_q, cur_track_d;
    logic [3:0] sec_q, sec_d;
    logic       valid_q, valid_d, dirty_q, dirty_d, change_q, change_d;
    logic       ack_q, ack_rise, ack_fall, busy_q, busy_d, ready_q, host_we, sd_we, active;
    logic [7:0] ram_do_q, sd_din_q;
    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    assign ack_rise = bus.sd_ack & ~ack_q;
    assign ack_fall = ~bus.sd_ack & ack_q;
    assign active   = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        cur_track_d = cur_track_q;
        sec_d       = sec_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        change_d    = change_q;
        host_we     = 1'b0;
        sd_we       = 1'b0;
        case (state_q)
            IDLE: begin
                // A new image invalidates the buffer without any write-back.
                if (bus.change != change_q) begin
                    change_d = bus.change;
                    valid_d  = 1'b0;
                    dirty_d  = 1'b0;
                end
                if (!bus.mount) valid_d = 1'b0;
                if (bus.mount && (!valid_d || bus.track != cur_track_q)) begin
                    sec_d       = '0;
                    state_d     = RD_REQ;
                    cur_track_d = bus.track;
`ifdef FLOPPY_WRITEBACK_EN
                    if (dirty_d && valid_d) begin
                        state_d     = WR_REQ;
                        cur_track_d = cur_track_q;
                    end
`endif
                end else if (bus.ram_we && valid_d) begin
                    host_we = 1'b1;
                    dirty_d = 1'b1;
                end
            end
            RD_REQ: state_d = ack_rise ? RD_XFER : RD_REQ;
            RD_XFER: begin
                sd_we = bus.sd_ack & bus.sd_buff_wr;
                if (ack_fall) begin
                    if (!bus.mount) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else if (sec_q == LAST_SEC) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                    end else begin
                        sec_d   = sec_q + 4'd1;
                        state_d = RD_REQ;
                    end
                end
            end
`ifdef FLOPPY_WRITEBACK_EN
            WR_REQ: state_d = ack_rise ? WR_XFER : WR_REQ;
            WR_XFER: begin
                if (ack_fall) begin
                    if (!bus.mount) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        dirty_d = 1'b0;
                    end else if (sec_q == LAST_SEC) begin
                        dirty_d     = 1'b0;
                        cur_track_d = bus.track;
                        sec_d       = '0;
                        state_d     = RD_REQ;
                    end else begin
                        sec_d   = sec_q + 4'd1;
                        state_d = WR_REQ;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // A disk change seen outside IDLE keeps busy up until IDLE picks it up.
        busy_d = (state_d != IDLE) |
                 (bus.mount & (~valid_d | (bus.track != cur_track_d) | (bus.change != change_d)));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_track_q <= '1;
            sec_q       <= '0;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            change_q    <= bus.change;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            ram_do_q    <= '0;
            sd_din_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_track_q <= cur_track_d;
            sec_q       <= sec_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            change_q    <= change_d;
            ack_q       <= bus.sd_ack;
            busy_q      <= busy_d;
            ready_q     <= bus.mount & valid_d;
            ram_do_q    <= mem[bus.ram_addr];
            sd_din_q    <= mem[{sec_q, bus.sd_buff_addr}];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset && host_we) mem[bus.ram_addr] <= bus.ram_di;
        if (!reset && sd_we) mem[{sec_q, bus.sd_buff_addr}] <= bus.sd_buff_dout;
    end

    assign bus.ram_do      = ram_do_q;
    assign bus.sd_buff_din = sd_din_q;
    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;
    assign bus.active      = active;
    assign bus.sd_rd       = state_q == RD_REQ;
    assign bus.sd_lba      = active ? 32'(cur_track_q) * 32'(SECTORS_PER_TRACK) + 32'(sec_q) : '0;
`ifdef FLOPPY_WRITEBACK_EN
    assign bus.sd_wr       = state_q == WR_REQ;
`else
    assign bus.sd_wr       = 1'b0;
`endif
endmodule

// File: tb/tb_floppy_track_buffer.sv
// tb_floppy_track_buffer: random-data SD image emulator plus a byte-array model of the
// track buffer; checks request sequences, loaded/written data, reset and unmount behaviour.
module tb_floppy_track_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    floppy_track_buffer_if bus();
    floppy_track_buffer dut (.clk_sys(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

`ifdef FLOPPY_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          seed;
    bit          model_dirty;
    logic [7:0]  mb [8192];
    logic [7:0]  disk_w [int];
    logic [31:0] req_log [$];
    logic [31:0] exp_q [$];
    int          hi_addr [$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] disk_byte(int lba, int a);
        int idx;
        idx = lba * 512 + a;
        if (disk_w.exists(idx)) return disk_w[idx];
        return 8'((idx * 37) ^ (idx >> 5) ^ seed);
    endfunction

    function automatic void load_model(int t);
        for (int s = 0; s < 13; s++)
            for (int a = 0; a < 512; a++) mb[s * 512 + a] = disk_byte(t * 13 + s, a);
        model_dirty = 1'b0;
    endfunction

    function automatic void add_reqs(bit wr, int t);
        for (int s = 0; s < 13; s++) exp_q.push_back({wr, 31'(t * 13 + s)});
    endfunction

    // SD card: one request per sector, random ack latency, one DMA byte per cycle.
    initial begin
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        bus.sd_buff_addr = '0;
        bus.sd_buff_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset && !bus.sd_ack && (bus.sd_rd || bus.sd_wr)) begin
                bit wr;
                int lba;
                wr  = bus.sd_wr;
                lba = int'(bus.sd_lba);
                req_log.push_back({wr, bus.sd_lba[30:0]});
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.sd_ack = 1'b1;
                for (int i = 0; i < 512; i++) begin
                    @(negedge clk);
                    if (wr && i > 0) disk_w[lba * 512 + i - 1] = bus.sd_buff_din;
                    bus.sd_buff_addr = 9'(i);
                    if (!wr) begin
                        bus.sd_buff_dout = disk_byte(lba, i);
                        bus.sd_buff_wr = 1'b1;
                    end
                end
                @(negedge clk);
                if (wr) disk_w[lba * 512 + 511] = bus.sd_buff_din;
                bus.sd_buff_wr = 1'b0;
                bus.sd_ack = 1'b0;
            end
        end
    end

    task automatic wait_load(string tag, output bit ready_dropped);
        int n;
        n = 0;
        ready_dropped = 1'b0;
        repeat (3) @(negedge clk);
        while (bus.busy && n < 30000) begin
            if (!bus.ready) ready_dropped = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        check({tag, "_ready_end"}, 32'(bus.ready), 1);
    endtask

    task automatic wait_reqs(string tag, int n);
        int k;
        k = 0;
        while (!(req_log.size() >= n && bus.sd_ack) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reached"}, 32'(k < 20000), 1);
    endtask

    task automatic check_log(string tag);
        check({tag, "_nreq"}, 32'(req_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
            check($sformatf("%s_req%0d", tag, i), req_log[i], exp_q[i]);
        req_log.delete();
        exp_q.delete();
    endtask

    task automatic read_host(string tag, int a);
        bus.ram_addr = 13'(a);
        @(negedge clk);
        check(tag, 32'(bus.ram_do), 32'(mb[a]));
    endtask

    task automatic read_random(string tag, int n);
        for (int i = 0; i < n; i++) begin
            int a;
            if (hi_addr.size() > 0 && $urandom_range(0, 3) == 0)
                a = hi_addr[$urandom_range(0, hi_addr.size() - 1)];
            else
                a = int'($urandom_range(0, 6655));
            read_host($sformatf("%s_rd%0h", tag, a), a);
        end
    endtask

    task automatic write_host(int a, logic [7:0] d, bit takes);
        bus.ram_addr = 13'(a);
        bus.ram_di = d;
        bus.ram_we = 1'b1;
        @(negedge clk);
        bus.ram_we = 1'b0;
        if (takes) begin
            mb[a] = d;
            model_dirty = 1'b1;
        end
    endtask

    task automatic check_wb(string tag, int t);
        int bad;
        bad = 0;
        for (int i = 0; i < 6656; i++)
            if (!disk_w.exists(t * 6656 + i) || disk_w[t * 6656 + i] !== mb[i]) bad++;
        check(tag, 32'(bad), 0);
    endtask

    initial begin
        bit dropped;
        int t_a, t_b, t_c, h;
        bus.ram_addr = '0;
        bus.ram_di = '0;
        bus.ram_we = 1'b0;
        bus.track = 6'd0;
        bus.change = 1'b0;
        bus.mount = 1'b0;
        seed = int'($urandom);
        model_dirty = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_active", 32'(bus.active), 0);
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_sd_rd", 32'(bus.sd_rd), 0);
        check("rst_sd_wr", 32'(bus.sd_wr), 0);
        check("rst_sd_lba", bus.sd_lba, 0);
        check("rst_ram_do", 32'(bus.ram_do), 0);
        check("rst_sd_din", 32'(bus.sd_buff_din), 0);

        reset = 1'b0;
        bus.mount = 1'b1;
        add_reqs(1'b0, 0);
        wait_load("load0", dropped);
        check_log("load0");
        load_model(0);
        read_host("sec1_byte1", 'h201);
        read_random("load0", 8);

        add_reqs(1'b0, 5);
        bus.track = 6'd5;
        wait_load("t5", dropped);
        check("t5_ready_stays", 32'(dropped), 0);
        check_log("t5");
        load_model(5);
        read_random("t5", 8);

        write_host('h10, 8'hA5, 1'b1);
        for (int i = 0; i < 6; i++) write_host(int'($urandom_range(32, 6655)), 8'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) begin
            h = 6656 + int'($urandom_range(0, 1535));
            hi_addr.push_back(h);
            write_host(h, 8'($urandom), 1'b1);
        end
        read_host("wr_a5", 'h10);
        read_random("dirty5", 8);
        if (WB && model_dirty) add_reqs(1'b1, 5);
        add_reqs(1'b0, 6);
        bus.track = 6'd6;
        wait_load("t6", dropped);
        check_log("t6");
        if (WB) begin
            check_wb("wb5_data", 5);
            check("wb5_a5", 32'(disk_byte(65, 'h10)), 32'hA5);
        end
        load_model(6);
        read_random("t6", 8);

        for (int i = 0; i < 3; i++) write_host(int'($urandom_range(0, 6655)), 8'($urandom), 1'b1);
        seed = int'($urandom);
        disk_w.delete();
        add_reqs(1'b0, 6);
        bus.change = ~bus.change;
        wait_load("chg", dropped);
        check("chg_ready_drop", 32'(dropped), 1);
        check_log("chg");
        load_model(6);
        read_random("chg", 8);

        t_a = 10 + int'($urandom_range(0, 10));
        t_b = 21 + int'($urandom_range(0, 10));
        add_reqs(1'b0, t_a);
        add_reqs(1'b0, t_b);
        bus.track = 6'(t_a);
        wait_reqs("mid", 3);
        bus.track = 6'(t_b);
        wait_load("mid", dropped);
        check("mid_ready_stays", 32'(dropped), 0);
        check_log("mid");
        load_model(t_b);
        read_random("mid", 8);

        t_c = 1 + int'($urandom_range(0, 4));
        bus.track = 6'(t_c);
        wait_reqs("rst_mid", 5);
        reset = 1'b1;
        req_log.delete();
        @(negedge clk);
        check("rstmid_sd_rd", 32'(bus.sd_rd), 0);
        check("rstmid_busy", 32'(bus.busy), 0);
        check("rstmid_active", 32'(bus.active), 0);
        check("rstmid_sd_lba", bus.sd_lba, 0);
        reset = 1'b0;
        model_dirty = 1'b0;
        add_reqs(1'b0, t_c);
        wait_load("reload", dropped);
        check_log("reload");
        load_model(t_c);
        read_random("reload", 8);

        bus.mount = 1'b0;
        repeat (3) @(negedge clk);
        req_log.delete();
        check("unmnt_ready", 32'(bus.ready), 0);
        write_host(hi_addr[0], ~mb[hi_addr[0]], 1'b0);
        write_host(int'($urandom_range(0, 6655)), 8'($urandom), 1'b0);
        repeat (1000) @(negedge clk);
        check("unmnt_busy", 32'(bus.busy), 0);
        check("unmnt_ready_late", 32'(bus.ready), 0);
        check_log("unmnt");
        add_reqs(1'b0, t_c);
        bus.mount = 1'b1;
        wait_load("remnt", dropped);
        check_log("remnt");
        load_model(t_c);
        read_host("unmnt_wr_ignored", hi_addr[0]);
        read_random("remnt", 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
